riscv_decode_arbiter: RTL and testbench

- Shares one registered RISC-V instruction-type decoder among NUM_REQ instruction requesters, e.g. harts or fetch streams.
- Round-robin grant; at most one instruction is issued to the decoder per cycle.
- Tracks in-flight requester IDs through the decoder pipeline.
- Buffers decoded results in an in-order output queue, with credit-based backpressure so no decode result is ever dropped.
- Sits between the fetch queues and the per-hart issue logic.

---
 rtl/riscv_decode_arbiter.sv | 179 +++++++++++++++++
 tb/tb_riscv_decode_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decode_arbiter.sv
// Arbitrates NUM_REQ instruction streams onto one shared registered decoder.
// Define RISCV_DEC_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module riscv_decode_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int DEC_LAT   = 1,
   parameter int OUT_DEPTH = 2,
   parameter int INFO_W    = 64,
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*32-1:0] req_insn,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [31:0]          dec_insn,
   input  logic [INFO_W-1:0]    dec_info,
   output logic                 out_valid,
   output logic [IDW-1:0]       out_id,
   output logic [INFO_W-1:0]    out_info,
   input  logic                 out_ready
);

   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW = $clog2(OUT_DEPTH + 1);

   logic [NUM_REQ-1:0] gnt;
   logic [IDW-1:0]     gnt_id;
   logic               can_issue;
   logic               pop;
   logic               push;
   logic [IDW-1:0]     push_id;
   logic [INFO_W-1:0]  push_info;
   int                 inflight;

   logic [DEC_LAT-1:0] stg_vld;
   logic [IDW-1:0]     stg_id [DEC_LAT];

   logic [CW-1:0]      cnt;
   logic [CW-1:0]      remain;
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_nxt;
   logic [IDW-1:0]     mem_id   [OUT_DEPTH];
   logic [INFO_W-1:0]  mem_info [OUT_DEPTH];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pop = out_valid && out_ready;

   // Every issued instruction owns a queue slot from grant until pop.
   always_comb begin
      inflight = 0;
      for (int s = 0; s < DEC_LAT; s++)
         inflight += int'(stg_vld[s]);
      can_issue = (int'(cnt) + inflight) < (OUT_DEPTH + int'(pop));
   end

`ifdef RISCV_DEC_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
            gnt_id = IDW'(i);
         end
      end
      if (!can_issue || flush) begin
         gnt    = '0;
         gnt_id = '0;
      end
   end
`else
   logic [IDW-1:0] rr_ptr;
   logic           found;
   int             idx;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      if (can_issue && !flush) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ)
               idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
               found    = 1'b1;
               gnt[idx] = 1'b1;
               gnt_id   = IDW'(idx);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (|gnt)
         rr_ptr <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
   end
`endif

   assign req_ready = gnt;

   always_comb begin
      dec_insn = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt[i])
            dec_insn = req_insn[32*i +: 32];
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         stg_vld <= '0;
      end else begin
         stg_vld[0] <= |gnt;
         for (int s = 1; s < DEC_LAT; s++)
            stg_vld[s] <= stg_vld[s-1];
      end
   end

   always_ff @(posedge clk) begin
      stg_id[0] <= gnt_id;
      for (int s = 1; s < DEC_LAT; s++)
         stg_id[s] <= stg_id[s-1];
   end

   assign push      = stg_vld[DEC_LAT-1] && !flush;
   assign push_id   = stg_id[DEC_LAT-1];
   assign push_info = dec_info;

   assign out_valid = (cnt != '0);
   assign rd_nxt    = pop ? ptr_inc(rd_ptr) : rd_ptr;
   assign remain    = cnt - CW'(pop);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_id[wr_ptr]   <= push_id;
         mem_info[wr_ptr] <= push_info;
      end
   end

   // Head registers track the entry at the post-pop read pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         out_id   <= '0;
         out_info <= '0;
      end else if (flush) begin
         cnt    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         cnt    <= remain + CW'(push);
         rd_ptr <= rd_nxt;
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (remain != '0) begin
            out_id   <= mem_id[rd_nxt];
            out_info <= mem_info[rd_nxt];
         end else if (push) begin
            out_id   <= push_id;
            out_info <= push_info;
         end
      end
   end

   no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && cnt == CW'(OUT_DEPTH)));

endmodule

// File: tb/tb_riscv_decode_arbiter.sv
// Bench for riscv_decode_arbiter: scoreboard of granted instructions vs output queue.
module tb_riscv_decode_arbiter;

   localparam int NUM_REQ   = 2;
   localparam int DEC_LAT   = 1;
   localparam int OUT_DEPTH = 2;
   localparam int INFO_W    = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [63:0] req_insn = '0;
   logic [1:0]  req_ready;
   logic [31:0] dec_insn;
   logic [63:0] dec_info = '0;
   logic        out_valid;
   logic [0:0]  out_id;
   logic [63:0] out_info;
   logic        out_ready = 1'b0;

   int total = 0;
   int bad = 0;
   int n_pop = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic [0:0]  id;
      logic [31:0] insn;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   riscv_decode_arbiter #(
      .NUM_REQ(NUM_REQ), .DEC_LAT(DEC_LAT),
      .OUT_DEPTH(OUT_DEPTH), .INFO_W(INFO_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_insn(req_insn),
      .req_ready(req_ready), .dec_insn(dec_insn),
      .dec_info(dec_info), .out_valid(out_valid),
      .out_id(out_id), .out_info(out_info),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // One-cycle registered decoder model
   always @(posedge clk) dec_info <= {~dec_insn, dec_insn};

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         total++;
         if ((req_ready & ~req_valid) != 2'b00 || req_ready == 2'b11) begin
            bad++;
            $display("FAIL grant_legal ready=%b valid=%b", req_ready, req_valid);
         end
         if (out_valid && out_ready) begin
            n_pop++;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_extra got id=%0d info=%h want none", out_id, out_info);
            end else begin
               e = sb.pop_front();
               if (out_id !== e.id || out_info !== {~e.insn, e.insn}) begin
                  bad++;
                  $display("FAIL sb_data got id=%0d info=%h want id=%0d info=%h",
                           out_id, out_info, e.id, {~e.insn, e.insn});
               end
            end
         end
         total++;
         if (req_ready == 2'b00 && dec_insn !== 32'h0) begin
            bad++;
            $display("FAIL dec_idle got %h want 0", dec_insn);
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && req_valid[i]) begin
               total++;
               if (dec_insn !== req_insn[32*i +: 32]) begin
                  bad++;
                  $display("FAIL dec_insn got %h want %h", dec_insn, req_insn[32*i +: 32]);
               end
               sb.push_back('{id: 1'(i), insn: req_insn[32*i +: 32]});
            end
         end
         if (flush) sb.delete();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      out_ready = 1'b1;
      req_valid = '0;
      flush = 1'b0;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '0;
      out_ready = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || req_ready !== 2'b00 || dec_insn !== 32'h0 ||
          out_id !== 1'b0 || out_info !== 64'h0) begin
         bad++;
         $display("FAIL reset_state got v=%b rdy=%b insn=%h id=%0d info=%h want all 0",
                  out_valid, req_ready, dec_insn, out_id, out_info);
      end
      tick();
      rst_n = 1'b1;
      mon_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0 || req_ready !== 2'b00 || dec_insn !== 32'h0) begin
            bad++;
            $display("FAIL idle got v=%b rdy=%b insn=%h want 0", out_valid, req_ready, dec_insn);
         end
         tick();
      end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_g;
      out_ready = 1'b1;
      req_valid = 2'b11;
      for (int k = 0; k < 8; k++) begin
         req_insn = {32'(32'h2000_0000 + k), 32'(32'h1000_0000 + k)};
         exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
         @(negedge clk);
         total++;
         if (req_ready !== exp_g) begin
            bad++;
            $display("FAIL rr_grant k=%0d got %b want %b", k, req_ready, exp_g);
         end
         if (k >= 2) begin
            total++;
            if (out_valid !== 1'b1 || out_id !== 1'((k - 2) % 2)) begin
               bad++;
               $display("FAIL rr_out k=%0d got v=%b id=%0d want v=1 id=%0d",
                        k, out_valid, out_id, (k - 2) % 2);
            end
         end
         tick();
      end
      drain(4);
      @(negedge clk);
      total++;
      if (sb.size() != 0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rr_drain got left=%0d v=%b want 0", sb.size(), out_valid);
      end
      tick();
   endtask

   task automatic test_fixed_prio();
      logic [1:0] exp_g;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         req_valid = (k >= 5 && k < 7) ? 2'b10 : 2'b11;
         req_insn = {32'(32'h3000_0000 + k), 32'(32'h4000_0000 + k)};
         exp_g = (k >= 5 && k < 7) ? 2'b10 : 2'b01;
         @(negedge clk);
         total++;
         if (req_ready !== exp_g) begin
            bad++;
            $display("FAIL fp_grant k=%0d got %b want %b", k, req_ready, exp_g);
         end
         tick();
      end
      drain(4);
   endtask

   task automatic test_backpressure();
      int ng;
      int np0;
      np0 = n_pop;
      ng = 0;
      out_ready = 1'b0;
      req_valid = 2'b11;
      req_insn = {32'h40C5_8633, 32'h00B5_0533};
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (req_ready != 2'b00) ng++;
         tick();
      end
      total++;
      if (ng != 2) begin
         bad++;
         $display("FAIL bp_grants got %0d want 2", ng);
      end
      @(negedge clk);
      total++;
      if (req_ready !== 2'b00 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_stall got rdy=%b v=%b want 00/1", req_ready, out_valid);
      end
      tick();
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         total++;
         if (req_ready === 2'b00) begin
            bad++;
            $display("FAIL bp_resume k=%0d got no grant want grant", k);
         end
         tick();
      end
      drain(5);
      @(negedge clk);
      total++;
      if (sb.size() != 0 || n_pop - np0 != 8) begin
         bad++;
         $display("FAIL bp_count got left=%0d pops=%0d want 0/8", sb.size(), n_pop - np0);
      end
      tick();
   endtask

   task automatic test_flush();
      int hits;
      logic [1:0] exp_g;
      out_ready = 1'b0;
      req_valid = 2'b01;
      req_insn = {32'h0020_8113, 32'h0000_0013};
      repeat (3) tick();
      flush = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || req_ready !== 2'b00) begin
         bad++;
         $display("FAIL fl_full got v=%b rdy=%b want 1/00", out_valid, req_ready);
      end
      tick();
      flush = 1'b0;
      out_ready = 1'b1;
      req_valid = 2'b11;
`ifdef RISCV_DEC_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = 2'b10;
`endif
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || req_ready !== exp_g) begin
         bad++;
         $display("FAIL fl_empty got v=%b rdy=%b want 0/%b", out_valid, req_ready, exp_g);
      end
      tick();
      req_valid = 2'b10;
      req_insn = {32'h0010_0093, 32'h0000_0013};
      @(negedge clk);
      total++;
      if (req_ready !== 2'b10) begin
         bad++;
         $display("FAIL fl_issue got %b want 10", req_ready);
      end
      tick();
      flush = 1'b1;
      req_valid = 2'b11;
      @(negedge clk);
      total++;
      if (req_ready !== 2'b00) begin
         bad++;
         $display("FAIL fl_nogrant got %b want 00", req_ready);
      end
      tick();
      flush = 1'b0;
      hits = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) begin
            total++;
            if (req_ready !== 2'b01) begin
               bad++;
               $display("FAIL fl_rr got %b want 01", req_ready);
            end
         end
         if (out_valid && out_info[31:0] == 32'h0010_0093) hits++;
         tick();
         req_valid = 2'b00;
      end
      total++;
      if (hits != 0 || sb.size() != 0) begin
         bad++;
         $display("FAIL fl_drop got hits=%0d left=%0d want 0/0", hits, sb.size());
      end
   endtask

   task automatic test_wrap();
      int ng;
      int np0;
      np0 = n_pop;
      ng = 0;
      req_valid = 2'b11;
      for (int c = 0; c < 60 && ng < 10; c++) begin
         out_ready = (c % 2 == 0);
         req_insn = {32'(32'h5000_0000 + c), 32'(32'h6000_0000 + c)};
         @(negedge clk);
         if (req_ready != 2'b00) ng++;
         tick();
      end
      req_valid = 2'b00;
      total++;
      if (ng != 10) begin
         bad++;
         $display("FAIL wr_grants got %0d want 10", ng);
      end
      drain(8);
      @(negedge clk);
      total++;
      if (n_pop - np0 != 10 || sb.size() != 0) begin
         bad++;
         $display("FAIL wr_count got pops=%0d left=%0d want 10/0", n_pop - np0, sb.size());
      end
      tick();
   endtask

   initial begin
      test_reset();
`ifdef RISCV_DEC_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_fairness();
`endif
      test_backpressure();
      test_flush();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
